uart_tx_gen: RTL and testbench

UART_TX_GEN -- requirements
Module: uart_tx_gen

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_tx_gen.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud divisor helper.
// Optional macro UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

   // Frame sequencer states; PARITY exists only when parity is compiled in.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } uart_state_e;

   // Clock cycles per bit (integer division, remainder discarded).
   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit tick counter: counts 0..DIV-1 while enabled and pulses tick_o on
// the last count of each bit period. clear_i restarts the count from zero.
module uart_baud_gen #(
   parameter int DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise wrap at the end of each bit period.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Count register, zeroed by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop bits. Define UART_TX_PARITY_EN to include the parity bit.
module uart_tx_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              rs232_tx,
   output logic              busy,
   output logic              done
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
   localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_e       state_q, state_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic              accept;
   logic              tick;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   uart_baud_gen #(
      .DIV(BAUD_DIV)
   ) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear_i(accept),
      .en_i   (busy_q),
      .tick_o (tick)
   );

   // Frame sequencing: advance one bit per baud tick, drive the next line level.
   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      accept     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d      = par_q;
`endif
      case (state_q)
         IDLE: begin
            // Also covers the done cycle, so frames can run back to back.
            if (start) begin
               accept     = 1'b1;
               state_d    = START;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               shift_d    = data;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_d      = (^data) ^ 1'(PARITY_ODD);
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = PARITY;
                  tx_d      = par_q;
`else
                  state_d   = STOP;
                  tx_d      = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (stop_cnt_q == STOP_LAST) begin
                  state_d    = IDLE;
                  tx_d       = 1'b1;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  stop_cnt_d = 1'b0;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame and idles the line high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign rs232_tx = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Testbench for uart_tx_gen: three instances share stimulus
// (u0: 8N1, u1: 7 data / 2 stop, u2: 8 data with odd parity sense).
module tb_uart_tx_gen;

   localparam int DIV    = 50;
   localparam int CAPMAX = 1200;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] data;
   logic       u0_tx, u0_busy, u0_done;
   logic       u1_tx, u1_busy, u1_done;
   logic       u2_tx, u2_busy, u2_done;

   logic [2:0] cap_tx   [0:CAPMAX-1];
   logic [2:0] cap_busy [0:CAPMAX-1];
   logic [2:0] cap_done [0:CAPMAX-1];

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_gen #(.CLK_FREQ(50_000_000), .BAUD(1_000_000), .DATA_W(8),
                 .STOP_BITS(1), .PARITY_ODD(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .data(data),
      .rs232_tx(u0_tx), .busy(u0_busy), .done(u0_done));

   uart_tx_gen #(.CLK_FREQ(50_000_000), .BAUD(1_000_000), .DATA_W(7),
                 .STOP_BITS(2), .PARITY_ODD(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .data(data[6:0]),
      .rs232_tx(u1_tx), .busy(u1_busy), .done(u1_done));

   uart_tx_gen #(.CLK_FREQ(50_000_000), .BAUD(1_000_000), .DATA_W(8),
                 .STOP_BITS(1), .PARITY_ODD(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .data(data),
      .rs232_tx(u2_tx), .busy(u2_busy), .done(u2_done));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic int flen(input int w, input int stops);
      return (1 + w + PB + stops) * DIV;
   endfunction

   // Reference line level k cycles after the accept edge.
   function automatic logic exp_tx(input int w, input int stops, input int podd,
                                   input logic [7:0] d, input int k);
      int   b   = k / DIV;
      int   len = flen(w, stops);
      logic p   = (podd != 0);
      for (int i = 0; i < w; i++) p = p ^ d[i];
      if (k >= len) return 1'b1;
      if (b == 0) return 1'b0;
      if (b <= w) return d[b-1];
      if (PB == 1 && b == w + 1) return p;
      return 1'b1;
   endfunction

   // Cycles where captured line differs from the reference; r2 >= 0 means
   // a second frame with d2 is expected to start at capture index r2.
   function automatic int count_err(input int inst, input int w, input int stops,
                                    input int podd, input logic [7:0] d1,
                                    input logic [7:0] d2, input int r2, input int n);
      int e = 0;
      for (int k = 0; k < n; k++) begin
         logic x;
         if (r2 >= 0 && k >= r2) x = exp_tx(w, stops, podd, d2, k - r2);
         else x = exp_tx(w, stops, podd, d1, k);
         if (cap_tx[k][inst] !== x) e++;
      end
      return e;
   endfunction

   function automatic int count_busy(input int inst, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (cap_busy[k][inst] === 1'b1) c++;
      return c;
   endfunction

   function automatic int count_done(input int inst, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (cap_done[k][inst] === 1'b1) c++;
      return c;
   endfunction

   // Pulse start with d1, then record n cycles (index 0 = first cycle after
   // the accept edge). Start is re-driven with d2 so it is sampled at edge r2.
   task automatic capture(input logic [7:0] d1, input logic [7:0] d2,
                          input int r2, input bit scramble, input int n);
      @(posedge clk); #1;
      data  = d1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         cap_tx[k]   = {u2_tx, u1_tx, u0_tx};
         cap_busy[k] = {u2_busy, u1_busy, u0_busy};
         cap_done[k] = {u2_done, u1_done, u0_done};
         if (scramble) data = 8'($urandom);
         if (k + 1 == r2) begin
            start = 1'b1;
            data  = d2;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (u0_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", u0_tx); else n_pass++;
      n_checks++; if (u0_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", u0_busy); else n_pass++;
      n_checks++; if (u0_done !== 1'b0) $display("FAIL reset_done: got %b want 0", u0_done); else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      $display("test_reset: tx=%b busy=%b done=%b", u0_tx, u0_busy, u0_done);
   endtask

   task automatic test_basic();
      int L = flen(8, 1);
      int n = L + 3;
      int e;
      capture(8'h55, 8'h00, -1, 1'b0, n);
      e = count_err(0, 8, 1, 0, 8'h55, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL basic_tx_u0: %0d bad cycles, want 0", e); else n_pass++;
      n_checks++; if (cap_tx[0][0] !== 1'b0) $display("FAIL basic_start_bit: got %b want 0", cap_tx[0][0]); else n_pass++;
      n_checks++; if (cap_tx[DIV][0] !== 1'b1) $display("FAIL basic_bit0: got %b want 1", cap_tx[DIV][0]); else n_pass++;
      n_checks++; if (count_busy(0, n) !== L) $display("FAIL basic_busy_len: got %0d want %0d", count_busy(0, n), L); else n_pass++;
      n_checks++; if (cap_done[L][0] !== 1'b1) $display("FAIL basic_done_pos: got %b want 1", cap_done[L][0]); else n_pass++;
      n_checks++; if (cap_busy[L][0] !== 1'b0) $display("FAIL basic_busy_in_done: got %b want 0", cap_busy[L][0]); else n_pass++;
      n_checks++; if (count_done(0, n) !== 1) $display("FAIL basic_done_width: got %0d want 1", count_done(0, n)); else n_pass++;
      e = count_err(2, 8, 1, 1, 8'h55, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL basic_tx_u2: %0d bad cycles, want 0", e); else n_pass++;
      $display("test_basic: data=55 frame=%0d busy=%0d", L, count_busy(0, n));
   endtask

   task automatic test_parity();
      int L = flen(8, 1);
      int n = L + 3;
      int e;
      capture(8'h58, 8'h00, -1, 1'b0, n);
      e = count_err(0, 8, 1, 0, 8'h58, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL parity_tx_even: %0d bad cycles, want 0", e); else n_pass++;
      e = count_err(2, 8, 1, 1, 8'h58, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL parity_tx_odd: %0d bad cycles, want 0", e); else n_pass++;
`ifdef UART_TX_PARITY_EN
      n_checks++; if (cap_tx[9*DIV+25][0] !== 1'b1) $display("FAIL parity_bit_even: got %b want 1", cap_tx[9*DIV+25][0]); else n_pass++;
      n_checks++; if (cap_tx[9*DIV+25][2] !== 1'b0) $display("FAIL parity_bit_odd: got %b want 0", cap_tx[9*DIV+25][2]); else n_pass++;
      n_checks++; if (cap_done[550][0] !== 1'b1) $display("FAIL parity_len: done got %b want 1 at 550", cap_done[550][0]); else n_pass++;
`else
      n_checks++; if (cap_done[500][0] !== 1'b1) $display("FAIL noparity_len: done got %b want 1 at 500", cap_done[500][0]); else n_pass++;
      n_checks++; if (cap_tx[9*DIV+25][2] !== 1'b1) $display("FAIL noparity_stop_u2: got %b want 1", cap_tx[9*DIV+25][2]); else n_pass++;
`endif
      $display("test_parity: data=58 frame=%0d", L);
   endtask

   task automatic test_w7_stop2();
      int L = flen(7, 2);
      int n = L + 3;
      int e;
      capture(8'h38, 8'h00, -1, 1'b0, n);
      e = count_err(1, 7, 2, 0, 8'h38, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL w7_tx: %0d bad cycles, want 0", e); else n_pass++;
      n_checks++; if (cap_tx[L-2*DIV][1] !== 1'b1) $display("FAIL w7_stop_first: got %b want 1", cap_tx[L-2*DIV][1]); else n_pass++;
      n_checks++; if (cap_done[L][1] !== 1'b1) $display("FAIL w7_done_pos: got %b want 1", cap_done[L][1]); else n_pass++;
      n_checks++; if (count_busy(1, n) !== L) $display("FAIL w7_busy_len: got %0d want %0d", count_busy(1, n), L); else n_pass++;
      $display("test_w7_stop2: data=38 frame=%0d", L);
   endtask

   task automatic test_ignore_busy_start();
      int L = flen(8, 1);
      int n = L + 5;
      int e;
      capture(8'hB8, 8'hFF, 200, 1'b0, n);
      e = count_err(0, 8, 1, 0, 8'hB8, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL ignore_tx: %0d bad cycles, want 0", e); else n_pass++;
      n_checks++; if (count_done(0, n) !== 1) $display("FAIL ignore_done_count: got %0d want 1", count_done(0, n)); else n_pass++;
      n_checks++; if (count_busy(0, n) !== L) $display("FAIL ignore_busy_len: got %0d want %0d", count_busy(0, n), L); else n_pass++;
      $display("test_ignore_busy_start: data=B8 extra start at 200");
   endtask

   task automatic test_back_to_back();
      int L = flen(8, 1);
      int n = 2 * L + 3;
      int e;
      capture(8'hA3, 8'h5C, L + 1, 1'b0, n);
      e = count_err(0, 8, 1, 0, 8'hA3, 8'h5C, L + 1, n);
      n_checks++; if (e !== 0) $display("FAIL b2b_tx_u0: %0d bad cycles, want 0", e); else n_pass++;
      e = count_err(1, 7, 2, 0, 8'hA3, 8'h5C, L + 1, n);
      n_checks++; if (e !== 0) $display("FAIL b2b_tx_u1: %0d bad cycles, want 0", e); else n_pass++;
      n_checks++; if (cap_tx[L+1][0] !== 1'b0) $display("FAIL b2b_start_bit: got %b want 0", cap_tx[L+1][0]); else n_pass++;
      n_checks++; if (cap_busy[L+1][0] !== 1'b1) $display("FAIL b2b_busy: got %b want 1", cap_busy[L+1][0]); else n_pass++;
      n_checks++; if (cap_done[2*L+1][0] !== 1'b1) $display("FAIL b2b_done2: got %b want 1", cap_done[2*L+1][0]); else n_pass++;
      n_checks++; if (count_done(0, n) !== 2) $display("FAIL b2b_done_count: got %0d want 2", count_done(0, n)); else n_pass++;
      $display("test_back_to_back: A3 then 5C, gap 1 cycle");
   endtask

   task automatic test_data_hold();
      int L = flen(8, 1);
      int n = L + 3;
      int e;
      capture(8'h96, 8'h00, -1, 1'b1, n);
      data = 8'h00;
      e = count_err(0, 8, 1, 0, 8'h96, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL hold_tx_u0: %0d bad cycles, want 0", e); else n_pass++;
      e = count_err(1, 7, 2, 0, 8'h96, 8'h00, -1, n);
      n_checks++; if (e !== 0) $display("FAIL hold_tx_u1: %0d bad cycles, want 0", e); else n_pass++;
      $display("test_data_hold: data=96 scrambled after accept");
   endtask

   task automatic test_reset_mid();
      int low_cnt  = 0;
      int busy_cnt = 0;
      int done_cnt = 0;
      @(posedge clk); #1;
      data  = 8'h00;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (250) @(posedge clk);
      #5;
      n_checks++; if (u0_tx !== 1'b0) $display("FAIL rmid_pre_tx: got %b want 0", u0_tx); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (u0_tx !== 1'b1) $display("FAIL rmid_tx: got %b want 1", u0_tx); else n_pass++;
      n_checks++; if (u0_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", u0_busy); else n_pass++;
      n_checks++; if (u1_tx !== 1'b1) $display("FAIL rmid_tx_u1: got %b want 1", u1_tx); else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         if (u0_tx !== 1'b1 || u1_tx !== 1'b1) low_cnt++;
         if (u0_busy !== 1'b0 || u1_busy !== 1'b0) busy_cnt++;
         if (u0_done !== 1'b0 || u1_done !== 1'b0) done_cnt++;
      end
      n_checks++; if (low_cnt !== 0) $display("FAIL rmid_idle_line: %0d non-high cycles, want 0", low_cnt); else n_pass++;
      n_checks++; if (busy_cnt !== 0) $display("FAIL rmid_idle_busy: %0d busy cycles, want 0", busy_cnt); else n_pass++;
      n_checks++; if (done_cnt !== 0) $display("FAIL rmid_no_done: %0d done cycles, want 0", done_cnt); else n_pass++;
      $display("test_reset_mid: reset at cycle 250, line idle afterwards");
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      data  = 8'h00;
      test_reset();
      test_basic();
      test_parity();
      test_w7_stop2();
      test_ignore_busy_start();
      test_back_to_back();
      test_data_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
